// File: rtl/serial_byte_loader_pkg.sv
// Shared definitions for the serial byte loader: FSM state encoding and default word width.
package serial_byte_loader_pkg;

    localparam int SBL_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PRESENT = 2'd2
    } sbl_state_t;

endpackage

// File: rtl/serial_byte_loader_if.sv
// Serial-in / word-out bundle between the serial source, the loader and the octal register.
interface serial_byte_loader_if
    import serial_byte_loader_pkg::*;
#(
    parameter int WIDTH = SBL_WIDTH_DEF
);
    logic             frame_start;
    logic             ser_en;
    logic             ser_in;
    logic             d_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] d_out;
    logic             d_valid;
    logic             oe_n;
    logic             busy;
    logic             overrun;

    modport master (
        output frame_start, ser_en, ser_in, d_ready, clr_ovr,
        input  d_out, d_valid, oe_n, busy, overrun
    );

    modport slave (
        input  frame_start, ser_en, ser_in, d_ready, clr_ovr,
        output d_out, d_valid, oe_n, busy, overrun
    );
endinterface

// File: rtl/sbl_shift_reg.sv
// Serial-in shift register; shifts left (MSB first) or right (LSB first), with synchronous clear.
module sbl_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_byte_loader.sv
// Assembles a WIDTH-bit word from a strobed serial stream and presents it with valid/ready,
// driving the octal register's active-low output enable only while the word is valid.
//
// state   | meaning
// IDLE    | waiting for frame_start; ser_en ignored
// SHIFT   | collecting bits on ser_en; frame_start restarts the word
// PRESENT | word held on d_out until d_ready; frame_start without d_ready flags overrun
module serial_byte_loader
    import serial_byte_loader_pkg::*;
#(
    parameter int WIDTH     = SBL_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    serial_byte_loader_if.slave bus
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sbl_state_t       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] d_out_q;
    logic             d_valid_q;
    logic             oe_n_q;
    logic             busy_q;
    logic             overrun_q;
    logic             sr_clr;
    logic             sr_en;

    // Any frame_start that (re)enters SHIFT starts from an empty register.
    always_comb begin
        sr_clr = 1'b0;
        sr_en  = 1'b0;
        if (bus.frame_start) begin
            sr_clr = (state == ST_IDLE) || (state == ST_SHIFT) ||
                     ((state == ST_PRESENT) && bus.d_ready);
        end
        if ((state == ST_SHIFT) && bus.ser_en && !bus.frame_start) begin
            sr_en = 1'b1;
        end
    end

    // Completed word must include the bit being sampled on the final strobe.
    assign word_next = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.ser_in}
                                 : {bus.ser_in, sr_q[WIDTH-1:1]};

    sbl_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk (clk),
        .rst (rst),
        .clr (sr_clr),
        .en  (sr_en),
        .din (bus.ser_in),
        .q   (sr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.frame_start) begin
                        bit_cnt <= '0;
                    end else if (bus.ser_en) begin
                        if (bit_cnt == LAST) begin
                            d_out_q   <= word_next;
                            d_valid_q <= 1'b1;
                            oe_n_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ST_PRESENT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (bus.d_ready) begin
                        d_valid_q <= 1'b0;
                        oe_n_q    <= 1'b1;
                        if (bus.frame_start) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bit_cnt   <= '0;
                    d_valid_q <= 1'b0;
                    oe_n_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase

            if ((state == ST_PRESENT) && bus.frame_start && !bus.d_ready) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.d_out   = d_out_q;
    assign bus.d_valid = d_valid_q;
    assign bus.oe_n    = oe_n_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: an MSB-first and an LSB-first instance driven in lockstep.
module tb_serial_byte_loader;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_byte_loader_if #(.WIDTH(8)) bus_m ();
    serial_byte_loader_if #(.WIDTH(8)) bus_l ();

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fs, input logic en, input logic si,
                          input logic rdy, input logic co);
        bus_m.frame_start = fs;  bus_l.frame_start = fs;
        bus_m.ser_en      = en;  bus_l.ser_en      = en;
        bus_m.ser_in      = si;  bus_l.ser_in      = si;
        bus_m.d_ready     = rdy; bus_l.d_ready     = rdy;
        bus_m.clr_ovr     = co;  bus_l.clr_ovr     = co;
    endtask

    task automatic send_bit(input logic b, input int gap);
        set_in(1'b0, 1'b1, b, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checks++; if (bus_m.d_out !== 8'h00) begin errors++; $display("FAIL rst_dout actual=%h expected=00", bus_m.d_out); end
        checks++; if (bus_m.d_valid !== 1'b0) begin errors++; $display("FAIL rst_dvalid actual=%b expected=0", bus_m.d_valid); end
        checks++; if (bus_m.oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n actual=%b expected=1", bus_m.oe_n); end
        checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL rst_busy actual=%b expected=0", bus_m.busy); end
        checks++; if (bus_m.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun actual=%b expected=0", bus_m.overrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        logic [7:0] pat;
        pat = 8'hAA;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL msb_busy actual=%b expected=1", bus_m.busy); end
        for (int i = 0; i < 7; i++) send_bit(pat[7-i], 0);
        checks++; if (bus_m.d_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid actual=%b expected=0", bus_m.d_valid); end
        send_bit(pat[0], 0);
        checks++; if (bus_m.d_out !== 8'hAA) begin errors++; $display("FAIL msb_dout actual=%h expected=aa", bus_m.d_out); end
        checks++; if (bus_m.d_valid !== 1'b1) begin errors++; $display("FAIL msb_dvalid actual=%b expected=1", bus_m.d_valid); end
        checks++; if (bus_m.oe_n !== 1'b0) begin errors++; $display("FAIL msb_oe_n actual=%b expected=0", bus_m.oe_n); end
        checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL msb_busy_present actual=%b expected=0", bus_m.busy); end
    endtask

    task automatic test_lsb_first();
        checks++; if (bus_l.d_out !== 8'h55) begin errors++; $display("FAIL lsb_dout actual=%h expected=55", bus_l.d_out); end
        checks++; if (bus_l.d_valid !== 1'b1) begin errors++; $display("FAIL lsb_dvalid actual=%b expected=1", bus_l.d_valid); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_l.d_valid !== 1'b0) begin errors++; $display("FAIL lsb_accept_valid actual=%b expected=0", bus_l.d_valid); end
        checks++; if (bus_l.oe_n !== 1'b1) begin errors++; $display("FAIL lsb_accept_oe_n actual=%b expected=1", bus_l.oe_n); end
        checks++; if (bus_l.d_out !== 8'h55) begin errors++; $display("FAIL lsb_hold_dout actual=%h expected=55", bus_l.d_out); end
        checks++; if (bus_m.d_out !== 8'hAA) begin errors++; $display("FAIL msb_hold_dout actual=%h expected=aa", bus_m.d_out); end
        // ser_en in IDLE must not start anything
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (9) tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_m.busy !== 1'b0 || bus_m.d_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore busy=%b valid=%b expected=0,0", bus_m.busy, bus_m.d_valid); end
    endtask

    task automatic test_abort();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL abort_busy actual=%b expected=1", bus_m.busy); end
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        checks++; if (bus_m.d_valid !== 1'b0) begin errors++; $display("FAIL abort_no_word actual=%b expected=0", bus_m.d_valid); end
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        checks++; if (bus_m.d_out !== 8'hFF) begin errors++; $display("FAIL abort_dout_m actual=%h expected=ff", bus_m.d_out); end
        checks++; if (bus_l.d_out !== 8'hFF) begin errors++; $display("FAIL abort_dout_l actual=%h expected=ff", bus_l.d_out); end
        checks++; if (bus_m.d_valid !== 1'b1) begin errors++; $display("FAIL abort_dvalid actual=%b expected=1", bus_m.d_valid); end
        checks++; if (bus_m.overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun actual=%b expected=0", bus_m.overrun); end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] pat;
        pat = 8'h96;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) send_bit(pat[7-i], 0);
        checks++; if (bus_m.d_out !== 8'h96) begin errors++; $display("FAIL ovr_dout_m actual=%h expected=96", bus_m.d_out); end
        checks++; if (bus_l.d_out !== 8'h69) begin errors++; $display("FAIL ovr_dout_l actual=%h expected=69", bus_l.d_out); end
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_m.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set actual=%b expected=1", bus_m.overrun); end
        checks++; if (bus_m.d_out !== 8'h96) begin errors++; $display("FAIL ovr_dout_hold actual=%h expected=96", bus_m.d_out); end
        checks++; if (bus_m.d_valid !== 1'b1 || bus_m.busy !== 1'b0) begin errors++; $display("FAIL ovr_stay_present valid=%b busy=%b expected=1,0", bus_m.d_valid, bus_m.busy); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus_m.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear actual=%b expected=0", bus_m.overrun); end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus_m.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_priority actual=%b expected=1", bus_m.overrun); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL ready_restart_busy actual=%b expected=1", bus_m.busy); end
        checks++; if (bus_m.d_valid !== 1'b0 || bus_m.oe_n !== 1'b1) begin errors++; $display("FAIL ready_restart_hs valid=%b oe_n=%b expected=0,1", bus_m.d_valid, bus_m.oe_n); end
        checks++; if (bus_m.overrun !== 1'b0 || bus_m.d_out !== 8'h96) begin errors++; $display("FAIL ready_restart_state ovr=%b dout=%h expected=0,96", bus_m.overrun, bus_m.d_out); end
    endtask

    task automatic test_gaps_and_reset();
        logic [7:0] pat;
        pat = 8'h4D;
        for (int i = 0; i < 7; i++) send_bit(pat[7-i], 3);
        checks++; if (bus_m.d_valid !== 1'b0 || bus_m.busy !== 1'b1) begin errors++; $display("FAIL gap_wait valid=%b busy=%b expected=0,1", bus_m.d_valid, bus_m.busy); end
        send_bit(pat[0], 0);
        checks++; if (bus_m.d_out !== 8'h4D) begin errors++; $display("FAIL gap_dout_m actual=%h expected=4d", bus_m.d_out); end
        checks++; if (bus_l.d_out !== 8'hB2) begin errors++; $display("FAIL gap_dout_l actual=%h expected=b2", bus_l.d_out); end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        checks++; if (bus_m.busy !== 1'b1 || bus_m.overrun !== 1'b1) begin errors++; $display("FAIL pre_rst busy=%b ovr=%b expected=1,1", bus_m.busy, bus_m.overrun); end
        rst = 1'b1;
        #1;
        checks++; if (bus_m.d_out !== 8'h00 || bus_l.d_out !== 8'h00) begin errors++; $display("FAIL async_rst_dout m=%h l=%h expected=00", bus_m.d_out, bus_l.d_out); end
        checks++; if (bus_m.d_valid !== 1'b0 || bus_m.oe_n !== 1'b1) begin errors++; $display("FAIL async_rst_hs valid=%b oe_n=%b expected=0,1", bus_m.d_valid, bus_m.oe_n); end
        checks++; if (bus_m.busy !== 1'b0 || bus_m.overrun !== 1'b0) begin errors++; $display("FAIL async_rst_flags busy=%b ovr=%b expected=0,0", bus_m.busy, bus_m.overrun); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_abort();
        test_overrun();
        test_gaps_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
